// File: rtl/uart_fifo_if.sv
// Handshake bundle for uart_fifo: TX push side and RX pop side.
// master = client logic (host/loader), slave = the UART.
interface uart_fifo_if #(
    parameter int unsigned data_bits = 8
);
    logic [data_bits-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [data_bits-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: full-duplex UART with configurable frame format, RX/TX FIFOs and
// sticky framing/parity/overrun flags. Optional feature: define UART_LOOPBACK_EN
// to add a loopback input that routes the TX stream into the receiver.
module uart_fifo #(
    parameter int unsigned clock_frequency = 12000000,
    parameter int unsigned baud_rate       = 9600,
    parameter int unsigned data_bits       = 8,
    parameter int unsigned parity          = 0,
    parameter int unsigned stop_bits       = 1,
    parameter int unsigned fifo_depth      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    output logic                        tx,
    uart_fifo_if.slave                  bus,
    input  logic                        clear,
`ifdef UART_LOOPBACK_EN
    input  logic                        loopback,
`endif
    output logic [$clog2(fifo_depth):0] tx_level,
    output logic [$clog2(fifo_depth):0] rx_level,
    output logic                        frame_error,
    output logic                        parity_error,
    output logic                        overrun,
    output logic                        busy
);
    localparam int unsigned divisor = clock_frequency / baud_rate;
    localparam int unsigned half    = divisor / 2;
    localparam int unsigned cw      = $clog2(divisor);
    localparam int unsigned aw      = $clog2(fifo_depth);
    localparam int unsigned lw      = aw + 1;
    localparam bit          odd_par = (parity == 2);

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
    typedef enum logic [2:0] {TxIdle, TxLoad, TxStart, TxData, TxParity, TxStop} tx_state_e;

    logic                 rx_meta_q, rx_sync_q, rx_prev_q, rx_in;
    rx_state_e            rx_state_q;
    logic [cw-1:0]        rx_cnt_q;
    logic [3:0]           rx_idx_q;
    logic [data_bits-1:0] rx_shift_q;
    logic                 rx_perr_q, rx_ferr_q, rx_done_q;

    logic [data_bits-1:0] rx_mem [fifo_depth];
    logic [aw-1:0]        rx_wptr_q, rx_rptr_q;
    logic [lw-1:0]        rx_level_q;
    logic                 rx_full, rx_push, rx_pop, rx_overrun;

    logic [data_bits-1:0] tx_mem [fifo_depth];
    logic [aw-1:0]        tx_wptr_q, tx_rptr_q;
    logic [lw-1:0]        tx_level_q;
    logic                 tx_full, tx_empty, tx_push, tx_pop;
    logic [data_bits-1:0] tx_head;

    tx_state_e            tx_state_q;
    logic [cw-1:0]        tx_cnt_q;
    logic [3:0]           tx_idx_q;
    logic [data_bits-1:0] tx_shift_q;
    logic                 tx_par_q, tx_q, tx_bit_end, tx_last_stop;

    logic                 frame_error_q, parity_error_q, overrun_q;

`ifdef UART_LOOPBACK_EN
    assign rx_in = loopback ? tx_q : rx_sync_q;
    assign tx    = loopback ? 1'b1 : tx_q;
`else
    assign rx_in = rx_sync_q;
    assign tx    = tx_q;
`endif

    assign rx_full    = (rx_level_q == lw'(fifo_depth));
    assign rx_push    = rx_done_q & ~rx_ferr_q & ~rx_perr_q & ~rx_full & ~clear;
    assign rx_overrun = rx_done_q & ~rx_ferr_q & ~rx_perr_q & rx_full;
    assign rx_pop     = bus.rx_ready & (rx_level_q != '0);

    assign tx_full      = (tx_level_q == lw'(fifo_depth));
    assign tx_empty     = (tx_level_q == '0);
    assign tx_push      = bus.tx_valid & ~tx_full;
    assign tx_head      = tx_mem[tx_rptr_q];
    assign tx_bit_end   = (tx_cnt_q == cw'(divisor - 1));
    assign tx_last_stop = (tx_idx_q == 4'(stop_bits - 1));
    // The shifter takes the head when idle or straight out of the final stop bit.
    assign tx_pop = ~tx_empty & ((tx_state_q == TxIdle) |
                                 ((tx_state_q == TxStop) & tx_bit_end & tx_last_stop));

    assign bus.tx_ready = ~tx_full;
    assign bus.rx_valid = (rx_level_q != '0);
    assign bus.rx_data  = rx_mem[rx_rptr_q];
    assign tx_level     = tx_level_q;
    assign rx_level     = rx_level_q;
    assign frame_error  = frame_error_q;
    assign parity_error = parity_error_q;
    assign overrun      = overrun_q;
    assign busy         = (rx_state_q != RxIdle) | (tx_state_q != TxIdle) | ~tx_empty;

    // Two-flop synchroniser on the pin plus the edge-detect history of the RX input.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_in;
        end
    end

    // Receive FSM: half-bit start check, then mid-bit sampling of every later bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            unique case (rx_state_q)
                RxIdle: begin
                    if (rx_prev_q && !rx_in) begin
                        rx_state_q <= RxStart;
                        rx_cnt_q   <= '0;
                    end
                end
                RxStart: begin
                    if (rx_cnt_q == cw'(half - 1)) begin
                        rx_cnt_q   <= '0;
                        rx_idx_q   <= '0;
                        rx_perr_q  <= 1'b0;
                        rx_ferr_q  <= 1'b0;
                        // A line back high at mid-start is a glitch, not a frame.
                        rx_state_q <= rx_in ? RxIdle : RxData;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == cw'(divisor - 1)) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_in, rx_shift_q[data_bits-1:1]};
                        if (rx_idx_q == 4'(data_bits - 1)) begin
                            rx_idx_q   <= '0;
                            rx_state_q <= (parity != 0) ? RxParity : RxStop;
                        end else begin
                            rx_idx_q <= rx_idx_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RxParity: begin
                    if (rx_cnt_q == cw'(divisor - 1)) begin
                        rx_cnt_q   <= '0;
                        rx_perr_q  <= rx_in ^ (^rx_shift_q) ^ odd_par;
                        rx_state_q <= RxStop;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == cw'(divisor - 1)) begin
                        rx_cnt_q  <= '0;
                        rx_ferr_q <= rx_ferr_q | ~rx_in;
                        if (rx_idx_q == 4'(stop_bits - 1)) begin
                            // Leave at mid-stop so a back-to-back start edge is not missed.
                            rx_state_q <= RxIdle;
                            rx_done_q  <= 1'b1;
                        end else begin
                            rx_idx_q <= rx_idx_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    // RX FIFO storage; written only when a good frame is accepted.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr_q] <= rx_shift_q;
    end

    // RX FIFO pointers and occupancy; clear flushes it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_level_q <= '0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
            if (rx_push && !rx_pop)      rx_level_q <= rx_level_q + 1'b1;
            else if (!rx_push && rx_pop) rx_level_q <= rx_level_q - 1'b1;
        end
    end

    // Sticky error flags; an error event in the same cycle as clear still sets its flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_error_q  <= 1'b0;
            parity_error_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            frame_error_q  <= (frame_error_q & ~clear) | (rx_done_q & rx_ferr_q);
            parity_error_q <= (parity_error_q & ~clear) | (rx_done_q & rx_perr_q);
            overrun_q      <= (overrun_q & ~clear) | rx_overrun;
        end
    end

    // TX FIFO storage; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= bus.tx_data;
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_level_q <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
            if (tx_push && !tx_pop)      tx_level_q <= tx_level_q + 1'b1;
            else if (!tx_push && tx_pop) tx_level_q <= tx_level_q - 1'b1;
        end
    end

    // Transmit FSM; tx_q holds the bit of the current state for exactly divisor clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            unique case (tx_state_q)
                TxIdle: begin
                    tx_q <= 1'b1;
                    if (tx_pop) begin
                        tx_shift_q <= tx_head;
                        tx_par_q   <= (^tx_head) ^ odd_par;
                        tx_state_q <= TxLoad;
                    end
                end
                TxLoad: begin
                    tx_state_q <= TxStart;
                    tx_cnt_q   <= '0;
                    tx_q       <= 1'b0;
                end
                TxStart: begin
                    if (tx_bit_end) begin
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_state_q <= TxData;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TxData: begin
                    if (tx_bit_end) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == 4'(data_bits - 1)) begin
                            tx_idx_q <= '0;
                            if (parity != 0) begin
                                tx_state_q <= TxParity;
                                tx_q       <= tx_par_q;
                            end else begin
                                tx_state_q <= TxStop;
                                tx_q       <= 1'b1;
                            end
                        end else begin
                            tx_idx_q   <= tx_idx_q + 1'b1;
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TxParity: begin
                    if (tx_bit_end) begin
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= '0;
                        tx_q       <= 1'b1;
                        tx_state_q <= TxStop;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TxStop: begin
                    if (tx_bit_end) begin
                        tx_cnt_q <= '0;
                        if (tx_last_stop) begin
                            tx_idx_q <= '0;
                            if (tx_pop) begin
                                // Chain straight into the next start bit: no idle gap.
                                tx_shift_q <= tx_head;
                                tx_par_q   <= (^tx_head) ^ odd_par;
                                tx_state_q <= TxStart;
                                tx_q       <= 1'b0;
                            end else begin
                                tx_state_q <= TxIdle;
                                tx_q       <= 1'b1;
                            end
                        end else begin
                            tx_idx_q <= tx_idx_q + 1'b1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end
endmodule
